// File: rtl/morph_filter.sv
// Binary erode/dilate stage over a causal KSIZE x KSIZE window with a fixed 3-clock latency.
// Define MORPH_BORDER_PAD_EN to pad out-of-frame window taps with the neutral value.
module morph_filter #(
  parameter int IMG_WIDTH = 640,
  parameter int KSIZE     = 3,
  parameter int CNT_W     = 11
) (
  input  logic pclk,
  input  logic rst,
  input  logic mode,
  input  logic din_hs,
  input  logic din_vs,
  input  logic din_de,
  input  logic din,
  output logic dout_hs,
  output logic dout_vs,
  output logic dout_de,
  output logic dout
);
  localparam int NL = KSIZE - 1;
  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] ROW_MAX = '1;

  logic [2:0]             hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic [CNT_W-1:0]       col_q, col_d, row_q, row_d;
  logic                   mode_act_q, mode_act_d;
  logic [KSIZE-1:0][KSIZE-1:0] win_q, win_d, win_m;  // [line tap][column age]
  logic                   mode_s1_q, mode_s1_d, mode_s2_q, mode_s2_d;
  logic [KSIZE-1:0]       rowred_q, rowred_d;
  logic                   dout_q, dout_d;
  logic [NL-1:0]          tap_rd, ram_wd;
  logic [KSIZE-1:0]       tap;
  logic [AW-1:0]          addr;
  logic                   vs_rise, de_fall;

  assign addr    = col_q[AW-1:0];
  assign vs_rise = din_vs & ~vs_q[0];
  assign de_fall = de_q[0] & ~din_de;
  assign tap     = {tap_rd, din};
  // Each line RAM takes the line that the RAM below it just handed out.
  assign ram_wd  = {tap_rd[NL-2:0], din};

  for (genvar gi = 0; gi < NL; gi++) begin : g_line
    logic line_ram [0:IMG_WIDTH-1];
    assign tap_rd[gi] = line_ram[addr];
    always_ff @(posedge pclk) begin
      if (din_de) line_ram[addr] <= ram_wd[gi];
    end
  end

  always_comb begin
    hs_d = {hs_q[1:0], din_hs};
    vs_d = {vs_q[1:0], din_vs};
    de_d = {de_q[1:0], din_de};

    col_d = col_q;
    if (din_de)       col_d = (col_q == COL_MAX) ? col_q : col_q + CNT_W'(1);
    else if (de_fall) col_d = '0;

    row_d = row_q;
    if (vs_rise)                          row_d = '0;
    else if (de_fall && row_q != ROW_MAX) row_d = row_q + CNT_W'(1);

    mode_act_d = vs_rise ? mode : mode_act_q;

    win_d     = win_q;
    mode_s1_d = mode_s1_q;
    if (din_de) begin
      for (int k = 0; k < KSIZE; k++) win_d[k] = {win_q[k][KSIZE-2:0], tap[k]};
      mode_s1_d = mode_act_d;
    end

    for (int k = 0; k < KSIZE; k++) rowred_d[k] = mode_s1_q ? |win_m[k] : &win_m[k];
    mode_s2_d = mode_s1_q;
    dout_d    = de_q[1] & (mode_s2_q ? |rowred_q : &rowred_q);
  end

`ifdef MORPH_BORDER_PAD_EN
  logic [CNT_W-1:0] col_s1_q, col_s1_d, row_s1_q, row_s1_d;

  always_comb begin
    col_s1_d = col_q;
    row_s1_d = vs_rise ? '0 : row_q;
    if (!din_de) begin
      col_s1_d = col_s1_q;
      row_s1_d = row_s1_q;
    end
    // Taps left of column 0 or above row 0 become neutral so they never decide the result.
    for (int k = 0; k < KSIZE; k++) begin
      for (int j = 0; j < KSIZE; j++) begin
        if (CNT_W'(j) > col_s1_q || CNT_W'(k) > row_s1_q) win_m[k][j] = ~mode_s1_q;
        else                                              win_m[k][j] = win_q[k][j];
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      col_s1_q <= '0;
      row_s1_q <= '0;
    end else begin
      col_s1_q <= col_s1_d;
      row_s1_q <= row_s1_d;
    end
  end
`else
  assign win_m = win_q;
`endif

  always_ff @(posedge pclk) begin
    if (rst) begin
      hs_q       <= '0;
      vs_q       <= '0;
      de_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      mode_act_q <= 1'b1;
      win_q      <= '0;
      mode_s1_q  <= 1'b1;
      mode_s2_q  <= 1'b1;
      rowred_q   <= '0;
      dout_q     <= 1'b0;
    end else begin
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      de_q       <= de_d;
      col_q      <= col_d;
      row_q      <= row_d;
      mode_act_q <= mode_act_d;
      win_q      <= win_d;
      mode_s1_q  <= mode_s1_d;
      mode_s2_q  <= mode_s2_d;
      rowred_q   <= rowred_d;
      dout_q     <= dout_d;
    end
  end

  assign dout_hs = hs_q[2];
  assign dout_vs = vs_q[2];
  assign dout_de = de_q[2];
  assign dout    = dout_q;
endmodule
